// File: rtl/serial_com_aligner.sv
// rtl/serial_com_aligner.sv - serial-to-parallel lane aligner locking on COM symbols
//
// Purpose: hunts the 1-bit lane stream for COM_SYMBOL at any bit offset,
// confirms byte alignment with COM_COUNT consecutive aligned COMs, then
// delivers one byte per 8 clk32f cycles with a valid qualifier.
//
// Ports:
//   clk32f     in   1  serial bit clock, all state on rising edge
//   reset      in   1  asynchronous active-high reset
//   serial_in  in   1  serial lane data, MSB of each byte first
//   data_out   out  8  last aligned byte received while locked
//   valid_out  out  1  one-cycle pulse, data_out just took a non-COM byte
//   active     out  1  high while locked
module serial_com_aligner #(
    parameter logic [7:0]  COM_SYMBOL = 8'hBC,
    parameter int unsigned COM_COUNT  = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

    state_t     state_q;
    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] com_cnt_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       active_q;

    // Byte ending with the bit being sampled on this edge.
    logic [7:0] window;
    logic       boundary;
    logic       is_com;

    assign window   = {sr_q[6:0], serial_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_com   = (window == COM_SYMBOL);

    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state_q   <= HUNT;
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            sr_q    <= window;
            valid_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    // Every offset is a candidate; the counter stays parked
                    // so the first detected COM defines the byte phase.
                    bit_cnt_q <= 3'd0;
                    if (is_com) begin
                        com_cnt_q <= 4'd1;
                        if (COM_TARGET == 4'd1) begin
                            state_q  <= LOCKED;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= SYNC;
                        end
                    end
                end
                SYNC: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt_q <= com_cnt_q + 4'd1;
                            if ((com_cnt_q + 4'd1) == COM_TARGET) begin
                                state_q  <= LOCKED;
                                active_q <= 1'b1;
                            end
                        end else begin
                            // The failing byte is discarded; hunting resumes
                            // with the next bit, not a re-scan of this byte.
                            state_q   <= HUNT;
                            com_cnt_q <= 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        data_q  <= window;
                        valid_q <= !is_com;
                    end
                end
                default: begin
                    state_q   <= HUNT;
                    bit_cnt_q <= 3'd0;
                    com_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_com_aligner.sv
// tb/tb_serial_com_aligner.sv - directed self-checking bench for serial_com_aligner
module tb_serial_com_aligner;

    logic       clk32f;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_checks;
    int n_errs;
    int cyc;

    logic [7:0] got_q[$];
    int         got_cyc_q[$];

    serial_com_aligner #(
        .COM_SYMBOL (8'hBC),
        .COM_COUNT  (4)
    ) dut (
        .clk32f    (clk32f),
        .reset     (reset),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    initial clk32f = 1'b0;
    always #5 clk32f = ~clk32f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bit away from the edge, sample 1 time unit after the edge.
    task automatic send_bit(input logic b);
        @(negedge clk32f);
        serial_in = b;
        @(posedge clk32f);
        #1;
        cyc++;
        if (valid_out) begin
            got_q.push_back(data_out);
            got_cyc_q.push_back(cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic clear_capture();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk32f);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk32f);
            serial_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk32f);
        reset = 1'b0;
        clear_capture();
    endtask

    task automatic check_got(input string tag, input int idx, input logic [7:0] exp);
        logic [31:0] g;
        g = (idx < got_q.size()) ? {24'h0, got_q[idx]} : 32'hDEAD;
        check(tag, g, {24'h0, exp});
    endtask

    initial begin
        n_checks  = 0;
        n_errs    = 0;
        cyc       = 0;
        reset     = 1'b1;
        serial_in = 1'b0;

        // Reset held for 3 cycles with random serial data.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk32f);
            serial_in = 1'($urandom_range(0, 1));
            @(posedge clk32f);
            #1;
            check("rst_data", {24'h0, data_out}, 32'h00);
            check("rst_valid", {31'h0, valid_out}, 32'h0);
            check("rst_active", {31'h0, active}, 32'h0);
        end
        @(negedge clk32f);
        reset = 1'b0;
        clear_capture();

        // Aligned lock.
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("al_active_pre", {31'h0, active}, 32'h0);
        send_byte(8'hBC);
        check("al_active_lock", {31'h0, active}, 32'h1);
        check("al_no_emit", got_q.size(), 0);
        send_byte(8'hFF);
        check("al_ff_valid", {31'h0, valid_out}, 32'h1);
        check("al_ff_data", {24'h0, data_out}, 32'hFF);
        send_bit(1'b1);
        check("al_hold_data", {24'h0, data_out}, 32'hFF);
        check("al_hold_valid", {31'h0, valid_out}, 32'h0);
        for (int i = 6; i >= 0; i--) send_bit(7'b1101110 >> i);
        send_byte(8'hDD);
        send_byte(8'hCC);
        check("al_count", got_q.size(), 4);
        check_got("al_b0", 0, 8'hFF);
        check_got("al_b1", 1, 8'hEE);
        check_got("al_b2", 2, 8'hDD);
        check_got("al_b3", 3, 8'hCC);
        if (got_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("al_spacing", got_cyc_q[i] - got_cyc_q[i-1], 8);
        end

        // Arbitrary bit offset.
        do_reset();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        check("off_active", {31'h0, active}, 32'h1);
        send_byte(8'hBB);
        send_byte(8'hAA);
        check("off_count", got_q.size(), 2);
        check_got("off_b0", 0, 8'hBB);
        check_got("off_b1", 1, 8'hAA);

        // Broken sync then a clean run.
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h99);
        check("brk_active_99", {31'h0, active}, 32'h0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("brk_active_3", {31'h0, active}, 32'h0);
        send_byte(8'hBC);
        check("brk_active_4", {31'h0, active}, 32'h1);
        send_byte(8'h88);
        check("brk_count", got_q.size(), 1);
        check_got("brk_b0", 0, 8'h88);

        // Idle COMs while locked.
        send_byte(8'hBC);
        check("idl_bc1_data", {24'h0, data_out}, 32'hBC);
        check("idl_bc1_valid", {31'h0, valid_out}, 32'h0);
        send_byte(8'h77);
        check("idl_77_data", {24'h0, data_out}, 32'h77);
        check("idl_77_valid", {31'h0, valid_out}, 32'h1);
        send_byte(8'hBC);
        check("idl_bc2_data", {24'h0, data_out}, 32'hBC);
        check("idl_bc2_valid", {31'h0, valid_out}, 32'h0);
        check("idl_count", got_q.size(), 2);
        check_got("idl_b1", 1, 8'h77);

        // Asynchronous reset mid-byte while locked.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_active_pre", {31'h0, active}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_active_clr", {31'h0, active}, 32'h0);
        check("mid_data_clr", {24'h0, data_out}, 32'h00);
        check("mid_valid_clr", {31'h0, valid_out}, 32'h0);
        @(negedge clk32f);
        reset = 1'b0;
        clear_capture();
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("rl_active_3", {31'h0, active}, 32'h0);
        send_byte(8'hBC);
        check("rl_active_4", {31'h0, active}, 32'h1);
        send_byte(8'h42);
        check("rl_count", got_q.size(), 1);
        check_got("rl_b0", 0, 8'h42);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
